// File: rtl/axist_csr_responder.sv
// AVMM CSR responder for the AXI-ST/AIB harness: control, status, link and delay registers.
// Define AXIST_CSR_SCRATCH_EN to add a RW scratch register at offset 0x100C.
module axist_csr_responder #(
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] DLY_X_RST  = 32'h0000_000C,
  parameter logic [31:0] DLY_Y_RST  = 32'h0000_0020,
  parameter logic [31:0] DLY_Z_RST  = 32'h0000_1770,
  parameter logic [31:0] BAD_RDATA  = 32'hDEAD_BEEF
) (
  input  logic        avmm_clk,
  input  logic        avmm_rst,
  input  logic [31:0] i_address,
  input  logic        i_write,
  input  logic [31:0] i_writedata,
  input  logic        i_read,
  input  logic [3:0]  i_status,
  input  logic [3:0]  i_link_online,
  output logic [31:0] o_readdata,
  output logic        o_readdatavalid,
  output logic        o_test_start,
  output logic        o_pat_random,
  output logic [3:0]  o_pkt_code,
  output logic [31:0] o_dly_x,
  output logic [31:0] o_dly_y,
  output logic [31:0] o_dly_z,
  output logic        o_addr_err
);

  localparam logic [15:0] A_CTRL = 16'h1000;
  localparam logic [15:0] A_STAT = 16'h1004;
  localparam logic [15:0] A_LINK = 16'h1008;
  localparam logic [15:0] A_SCR  = 16'h100C;
  localparam logic [15:0] A_DLYX = 16'h2000;
  localparam logic [15:0] A_DLYY = 16'h2004;
  localparam logic [15:0] A_DLYZ = 16'h2008;
  localparam logic [15:0] A_BASE = 16'h5000;

  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] dly_x_q, dly_x_d;
  logic [31:0] dly_y_q, dly_y_d;
  logic [31:0] dly_z_q, dly_z_d;
  logic        start_q, start_d;
  logic        err_q, err_d;
  logic [3:0]  link_s1_q, link_s1_d;
  logic [3:0]  link_s2_q, link_s2_d;
  logic        vld_q [RD_LATENCY];
  logic        vld_d [RD_LATENCY];
  logic [31:0] dat_q [RD_LATENCY];
  logic [31:0] dat_d [RD_LATENCY];
`ifdef AXIST_CSR_SCRATCH_EN
  logic [31:0] scr_q, scr_d;
`endif

  logic        wr_acc, rd_acc;
  logic        hi_ok, mapped;
  logic        sel_ctrl, sel_stat, sel_link, sel_scr;
  logic        sel_x, sel_y, sel_z;
  logic [15:0] off;
  logic [31:0] rd_mux;

  always_comb begin
    wr_acc   = i_write & ~write_q;
    rd_acc   = i_read & ~read_q;
    off      = i_address[15:0];
    hi_ok    = (i_address[31:16] == A_BASE);
    sel_ctrl = hi_ok && (off == A_CTRL);
    sel_stat = hi_ok && (off == A_STAT);
    sel_link = hi_ok && (off == A_LINK);
    sel_x    = hi_ok && (off == A_DLYX);
    sel_y    = hi_ok && (off == A_DLYY);
    sel_z    = hi_ok && (off == A_DLYZ);
`ifdef AXIST_CSR_SCRATCH_EN
    sel_scr  = hi_ok && (off == A_SCR);
`else
    sel_scr  = 1'b0;
`endif
    mapped   = sel_ctrl | sel_stat | sel_link | sel_scr
             | sel_x | sel_y | sel_z;
  end

  // Read mux uses current register state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = BAD_RDATA;
    unique case (1'b1)
      sel_ctrl: rd_mux = ctrl_q;
      sel_stat: rd_mux = {28'b0, i_status};
      sel_link: rd_mux = {28'b0, link_s2_q};
      sel_x:    rd_mux = dly_x_q;
      sel_y:    rd_mux = dly_y_q;
      sel_z:    rd_mux = dly_z_q;
`ifdef AXIST_CSR_SCRATCH_EN
      sel_scr:  rd_mux = scr_q;
`endif
      default:  rd_mux = BAD_RDATA;
    endcase
  end

  always_comb begin
    write_d   = i_write;
    read_d    = i_read;
    ctrl_d    = ctrl_q;
    dly_x_d   = dly_x_q;
    dly_y_d   = dly_y_q;
    dly_z_d   = dly_z_q;
    start_d   = 1'b0;
    err_d     = err_q | ((wr_acc | rd_acc) & ~mapped);
    link_s1_d = i_link_online;
    link_s2_d = link_s1_q;
`ifdef AXIST_CSR_SCRATCH_EN
    scr_d     = scr_q;
`endif
    if (wr_acc) begin
      if (sel_ctrl) begin
        ctrl_d  = {i_writedata[31:1], 1'b0};
        start_d = i_writedata[0];
      end
      if (sel_x) dly_x_d = i_writedata;
      if (sel_y) dly_y_d = i_writedata;
      if (sel_z) dly_z_d = i_writedata;
`ifdef AXIST_CSR_SCRATCH_EN
      if (sel_scr) scr_d = i_writedata;
`endif
    end
  end

  always_comb begin
    vld_d[0] = rd_acc;
    dat_d[0] = rd_mux;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_ff @(posedge avmm_clk or posedge avmm_rst) begin
    if (avmm_rst) begin
      write_q   <= 1'b0;
      read_q    <= 1'b0;
      ctrl_q    <= '0;
      dly_x_q   <= DLY_X_RST;
      dly_y_q   <= DLY_Y_RST;
      dly_z_q   <= DLY_Z_RST;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
      link_s1_q <= '0;
      link_s2_q <= '0;
`ifdef AXIST_CSR_SCRATCH_EN
      scr_q     <= '0;
`endif
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      write_q   <= write_d;
      read_q    <= read_d;
      ctrl_q    <= ctrl_d;
      dly_x_q   <= dly_x_d;
      dly_y_q   <= dly_y_d;
      dly_z_q   <= dly_z_d;
      start_q   <= start_d;
      err_q     <= err_d;
      link_s1_q <= link_s1_d;
      link_s2_q <= link_s2_d;
`ifdef AXIST_CSR_SCRATCH_EN
      scr_q     <= scr_d;
`endif
      for (int i = 0; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign o_readdata      = dat_q[RD_LATENCY-1];
  assign o_readdatavalid = vld_q[RD_LATENCY-1];
  assign o_test_start    = start_q;
  assign o_pat_random    = ctrl_q[2];
  assign o_pkt_code      = ctrl_q[15:12];
  assign o_dly_x         = dly_x_q;
  assign o_dly_y         = dly_y_q;
  assign o_dly_z         = dly_z_q;
  assign o_addr_err      = err_q;

endmodule

// File: tb/tb_axist_csr_responder.sv
// Scoreboard bench for axist_csr_responder: read returns checked for data and latency.
module tb_axist_csr_responder;

  localparam int          L   = 2;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] i_address = '0;
  logic        i_write = 1'b0;
  logic [31:0] i_writedata = '0;
  logic        i_read = 1'b0;
  logic [3:0]  i_status = '0;
  logic [3:0]  i_link_online = '0;
  logic [31:0] o_readdata;
  logic        o_readdatavalid;
  logic        o_test_start;
  logic        o_pat_random;
  logic [3:0]  o_pkt_code;
  logic [31:0] o_dly_x, o_dly_y, o_dly_z;
  logic        o_addr_err;

  axist_csr_responder #(.RD_LATENCY(L)) dut (
    .avmm_clk(clk), .avmm_rst(rst),
    .i_address(i_address), .i_write(i_write),
    .i_writedata(i_writedata), .i_read(i_read),
    .i_status(i_status), .i_link_online(i_link_online),
    .o_readdata(o_readdata), .o_readdatavalid(o_readdatavalid),
    .o_test_start(o_test_start), .o_pat_random(o_pat_random),
    .o_pkt_code(o_pkt_code), .o_dly_x(o_dly_x),
    .o_dly_y(o_dly_y), .o_dly_z(o_dly_z),
    .o_addr_err(o_addr_err)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  int          start_cnt = 0;
  int          vld_cnt = 0;
  logic [31:0] exp_q [$];
  int          exp_cyc [$];

  always @(posedge clk) cyc = cyc + 1;

  // Read-return monitor: pops the scoreboard on every valid strobe.
  always @(negedge clk) begin
    if (o_test_start) start_cnt = start_cnt + 1;
    if (o_readdatavalid) begin
      logic [31:0] ed;
      int          ec;
      vld_cnt = vld_cnt + 1;
      checks  = checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected got=%h expected no valid", o_readdata);
      end else begin
        ed = exp_q.pop_front();
        ec = exp_cyc.pop_front();
        if (o_readdata !== ed || cyc !== ec)
          $display("FAIL rd_return got=%h@%0d expected=%h@%0d",
                   o_readdata, cyc, ed, ec);
        else
          passes = passes + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e,
                    input int hold);
    i_address = a;
    i_read    = 1'b1;
    exp_q.push_back(e);
    exp_cyc.push_back(cyc + L);
    tick(hold);
    i_read = 1'b0;
    tick(1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input int hold);
    i_address   = a;
    i_writedata = d;
    i_write     = 1'b1;
    tick(hold);
    i_write = 1'b0;
    tick(1);
  endtask

  task automatic drain;
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      tick(1);
      k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL drain_timeout got=%0d pending expected=0",
               exp_q.size());
      exp_q.delete();
      exp_cyc.delete();
    end else passes++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    checks++;
    if ({o_readdata, o_readdatavalid, o_test_start, o_pat_random,
         o_pkt_code, o_addr_err} !== 40'h0)
      $display("FAIL reset_ctl got=%h/%b/%b/%b/%h/%b expected all 0",
               o_readdata, o_readdatavalid, o_test_start,
               o_pat_random, o_pkt_code, o_addr_err);
    else passes++;
    checks++;
    if (o_dly_x !== 32'hC || o_dly_y !== 32'h20 || o_dly_z !== 32'h1770)
      $display("FAIL reset_dly got=%h/%h/%h expected=c/20/1770",
               o_dly_x, o_dly_y, o_dly_z);
    else passes++;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_delay_reset;
    rd(32'h5000_2000, 32'hC, 1);
    rd(32'h5000_2004, 32'h20, 1);
    rd(32'h5000_2008, 32'h1770, 1);
    drain();
  endtask

  task automatic test_write_delay;
    i_address   = 32'h5000_2008;
    i_writedata = 32'h1234;
    i_write     = 1'b1;
    tick(1);
    checks++;
    if (o_dly_z !== 32'h1234)
      $display("FAIL dly_z_wr got=%h expected=1234", o_dly_z);
    else passes++;
    tick(2);
    i_write = 1'b0;
    tick(1);
    checks++;
    if (o_dly_x !== 32'hC || o_dly_y !== 32'h20 || o_pkt_code !== 4'h0)
      $display("FAIL dly_other got=%h/%h/%h expected=c/20/0",
               o_dly_x, o_dly_y, o_pkt_code);
    else passes++;
    rd(32'h5000_2008, 32'h1234, 1);
    drain();
  endtask

  task automatic test_ctrl;
    int s0 = start_cnt;
    wr(32'h5000_1000, 32'h1005, 3);
    tick(2);
    checks++;
    if (start_cnt - s0 !== 1)
      $display("FAIL start_pulse got=%0d cycles expected=1",
               start_cnt - s0);
    else passes++;
    checks++;
    if (o_pat_random !== 1'b1 || o_pkt_code !== 4'h1)
      $display("FAIL ctrl_fields got=%b/%h expected=1/1",
               o_pat_random, o_pkt_code);
    else passes++;
    rd(32'h5000_1000, 32'h1004, 1);
    drain();
  endtask

  task automatic test_status_link;
    i_link_online = 4'hF;
    tick(2);
    rd(32'h5000_1008, 32'hF, 3);
    i_status = 4'b1011;
    rd(32'h5000_1004, 32'hB, 2);
    drain();
  endtask

  task automatic test_unmapped;
    checks++;
    if (o_addr_err !== 1'b0)
      $display("FAIL err_pre got=%b expected=0", o_addr_err);
    else passes++;
    rd(32'h5000_3000, BAD, 1);
    drain();
    checks++;
    if (o_addr_err !== 1'b1)
      $display("FAIL err_set got=%b expected=1", o_addr_err);
    else passes++;
    rd(32'h6000_2000, BAD, 1);
`ifdef AXIST_CSR_SCRATCH_EN
    wr(32'h5000_100C, 32'hA5A5, 1);
    rd(32'h5000_100C, 32'hA5A5, 1);
`else
    rd(32'h5000_100C, BAD, 1);
`endif
    drain();
    checks++;
    if (o_addr_err !== 1'b1)
      $display("FAIL err_sticky got=%b expected=1", o_addr_err);
    else passes++;
  endtask

  task automatic test_reset_mid;
    int v0 = vld_cnt;
    i_address = 32'h5000_2000;
    i_read    = 1'b1;
    tick(1);
    i_read = 1'b0;
    rst    = 1'b1;
    tick(1);
    checks++;
    if (o_dly_z !== 32'h1770 || o_addr_err !== 1'b0 ||
        o_pat_random !== 1'b0 || o_pkt_code !== 4'h0 ||
        o_readdatavalid !== 1'b0 || o_readdata !== 32'h0)
      $display("FAIL mid_reset got=%h/%b/%b/%h/%b expected=1770/0/0/0/0",
               o_dly_z, o_addr_err, o_pat_random, o_pkt_code,
               o_readdatavalid);
    else passes++;
    rst = 1'b0;
    tick(6);
    checks++;
    if (vld_cnt !== v0)
      $display("FAIL mid_valid got=%0d valids expected=0", vld_cnt - v0);
    else passes++;
  endtask

  task automatic test_back_to_back;
    rd(32'h5000_2000, 32'hC, 1);
    rd(32'h5000_2004, 32'h20, 1);
    drain();
  endtask

  task automatic test_rw_same;
    i_address   = 32'h5000_2000;
    i_writedata = 32'h55;
    i_write     = 1'b1;
    i_read      = 1'b1;
    exp_q.push_back(32'hC);
    exp_cyc.push_back(cyc + L);
    tick(1);
    i_write = 1'b0;
    i_read  = 1'b0;
    tick(1);
    checks++;
    if (o_dly_x !== 32'h55)
      $display("FAIL rw_write got=%h expected=55", o_dly_x);
    else passes++;
    rd(32'h5000_2000, 32'h55, 1);
    drain();
  endtask

  initial begin
    test_reset();
    test_delay_reset();
    test_write_delay();
    test_ctrl();
    test_status_link();
    test_unmapped();
    test_reset_mid();
    test_back_to_back();
    test_rw_same();
    tick(3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
